dual_issue_ctrl: RTL

- Issue sequencer between the fetch/decode pair buffer and the scoreboard.
- Latches one fetched instruction pair and presents it to the scoreboard's two slots.
- Splits pairs with intra-pair RAW/WAW dependencies into two sequential single issues, since the scoreboard only checks sources against its busy table and would stall forever on a same-pair WAW.
- Raises issue strobes to execute when the scoreboard does not stall; gives fetch a valid/ready handshake and reports stalls that exceed a limit.

---
 rtl/dual_issue_if.sv | 51 +++++
 rtl/dual_issue_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dual_issue_if.sv
// Fetch-pair and scoreboard-slot signals for the dual-issue sequencer.
// The master side is the controller, the slave side is the fetch/scoreboard environment.
interface dual_issue_if;
    localparam int unsigned REG_W = 5;

    logic             in_valid;
    logic             in_ready;
    logic             in1_vld;
    logic             in2_vld;
    logic [REG_W-1:0] in1_dest;
    logic [REG_W-1:0] in1_src1;
    logic [REG_W-1:0] in1_src2;
    logic             in1_we;
    logic [REG_W-1:0] in2_dest;
    logic [REG_W-1:0] in2_src1;
    logic [REG_W-1:0] in2_src2;
    logic             in2_we;
    logic             flush;
    logic             sb_stall;
    logic [REG_W-1:0] sb1_dest;
    logic [REG_W-1:0] sb1_src1;
    logic [REG_W-1:0] sb1_src2;
    logic [REG_W-1:0] sb2_dest;
    logic [REG_W-1:0] sb2_src1;
    logic [REG_W-1:0] sb2_src2;
    logic             sb1_we;
    logic             sb2_we;
    logic             issue1_valid;
    logic             issue2_valid;
    logic             stall_timeout;

    modport master (
        input  in_valid, in1_vld, in2_vld,
        input  in1_dest, in1_src1, in1_src2, in1_we,
        input  in2_dest, in2_src1, in2_src2, in2_we,
        input  flush, sb_stall,
        output in_ready,
        output sb1_dest, sb1_src1, sb1_src2, sb2_dest, sb2_src1, sb2_src2,
        output sb1_we, sb2_we, issue1_valid, issue2_valid, stall_timeout
    );

    modport slave (
        output in_valid, in1_vld, in2_vld,
        output in1_dest, in1_src1, in1_src2, in1_we,
        output in2_dest, in2_src1, in2_src2, in2_we,
        output flush, sb_stall,
        input  in_ready,
        input  sb1_dest, sb1_src1, sb1_src2, sb2_dest, sb2_src1, sb2_src2,
        input  sb1_we, sb2_we, issue1_valid, issue2_valid, stall_timeout
    );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Issue sequencer: buffers one fetched pair, splits dependent pairs into two single issues.
// Define DUAL_ISSUE_STATS_EN to add the cnt_pairs/cnt_singles/cnt_stalls statistics outputs.
module dual_issue_ctrl #(
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    dual_issue_if.master     bus
`ifdef DUAL_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_pairs,
    output logic [CNT_W-1:0] cnt_singles,
    output logic [CNT_W-1:0] cnt_stalls
`endif
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SCNT_W = $clog2(STALL_LIMIT + 1);

    if (STALL_LIMIT == 0 || CNT_W == 0) begin : g_param_chk
        $error("dual_issue_ctrl: STALL_LIMIT and CNT_W must be nonzero");
    end

    typedef enum logic [1:0] {S_EMPTY, S_PAIR, S_SPLIT_A, S_SPLIT_B} state_e;

    state_e             state_q, state_d;
    logic               b1_vld_q, b1_vld_d, b1_we_q, b1_we_d;
    logic               b2_vld_q, b2_vld_d, b2_we_q, b2_we_d;
    logic [REG_W-1:0]   b1_dest_q, b1_dest_d, b1_src1_q, b1_src1_d, b1_src2_q, b1_src2_d;
    logic [REG_W-1:0]   b2_dest_q, b2_dest_d, b2_src1_q, b2_src1_d, b2_src2_q, b2_src2_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               gate, busy, go, stalled, last_issue, pres1, pres2, split;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            b1_vld_q  <= 1'b0;
            b1_we_q   <= 1'b0;
            b1_dest_q <= '0;
            b1_src1_q <= '0;
            b1_src2_q <= '0;
            b2_vld_q  <= 1'b0;
            b2_we_q   <= 1'b0;
            b2_dest_q <= '0;
            b2_src1_q <= '0;
            b2_src2_q <= '0;
            scnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            b1_vld_q  <= b1_vld_d;
            b1_we_q   <= b1_we_d;
            b1_dest_q <= b1_dest_d;
            b1_src1_q <= b1_src1_d;
            b1_src2_q <= b1_src2_d;
            b2_vld_q  <= b2_vld_d;
            b2_we_q   <= b2_we_d;
            b2_dest_q <= b2_dest_d;
            b2_src1_q <= b2_src1_d;
            b2_src2_q <= b2_src2_d;
            scnt_q    <= scnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        b1_vld_d  = b1_vld_q;
        b1_we_d   = b1_we_q;
        b1_dest_d = b1_dest_q;
        b1_src1_d = b1_src1_q;
        b1_src2_d = b1_src2_q;
        b2_vld_d  = b2_vld_q;
        b2_we_d   = b2_we_q;
        b2_dest_d = b2_dest_q;
        b2_src1_d = b2_src1_q;
        b2_src2_d = b2_src2_q;
        scnt_d    = scnt_q;

        gate       = !rst && !bus.flush;
        busy       = (state_q != S_EMPTY);
        go         = gate && busy && !bus.sb_stall;
        stalled    = gate && busy && bus.sb_stall;
        last_issue = go && (state_q == S_PAIR || state_q == S_SPLIT_B);
        pres1      = (state_q == S_PAIR && b1_vld_q) || (state_q == S_SPLIT_A);
        pres2      = (state_q == S_PAIR && b2_vld_q) || (state_q == S_SPLIT_B);

        // A same-pair producer (x0 excluded) forces slot 2 to wait behind slot 1
        split = bus.in1_vld && bus.in2_vld && bus.in1_we && (bus.in1_dest != '0) &&
                ((bus.in2_src1 == bus.in1_dest) || (bus.in2_src2 == bus.in1_dest) ||
                 (bus.in2_we && (bus.in2_dest == bus.in1_dest)));

        bus.in_ready      = gate && (!busy || last_issue);
        bus.sb1_dest      = pres1 ? b1_dest_q : '0;
        bus.sb1_src1      = pres1 ? b1_src1_q : '0;
        bus.sb1_src2      = pres1 ? b1_src2_q : '0;
        bus.sb1_we        = gate && pres1 && b1_we_q;
        bus.sb2_dest      = pres2 ? b2_dest_q : '0;
        bus.sb2_src1      = pres2 ? b2_src1_q : '0;
        bus.sb2_src2      = pres2 ? b2_src2_q : '0;
        bus.sb2_we        = gate && pres2 && b2_we_q;
        bus.issue1_valid  = go && pres1;
        bus.issue2_valid  = go && pres2;
        bus.stall_timeout = stalled && (scnt_q == SCNT_W'(STALL_LIMIT - 1));

        if (bus.flush) begin
            state_d = S_EMPTY;
            scnt_d  = '0;
        end else begin
            if (go) begin
                scnt_d  = '0;
                state_d = (state_q == S_SPLIT_A) ? S_SPLIT_B : S_EMPTY;
            end else if (stalled && (scnt_q != SCNT_W'(STALL_LIMIT))) begin
                scnt_d = scnt_q + SCNT_W'(1);
            end

            // Load may coincide with the final issue of the previous pair
            if (bus.in_valid && bus.in_ready) begin
                b1_vld_d  = bus.in1_vld;
                b1_we_d   = bus.in1_we;
                b1_dest_d = bus.in1_dest;
                b1_src1_d = bus.in1_src1;
                b1_src2_d = bus.in1_src2;
                b2_vld_d  = bus.in2_vld;
                b2_we_d   = bus.in2_we;
                b2_dest_d = bus.in2_dest;
                b2_src1_d = bus.in2_src1;
                b2_src2_d = bus.in2_src2;
                if (!bus.in1_vld && !bus.in2_vld) state_d = S_EMPTY;
                else if (split)                   state_d = S_SPLIT_A;
                else                              state_d = S_PAIR;
            end
        end
    end

`ifdef DUAL_ISSUE_STATS_EN
    logic [CNT_W-1:0] cnt_pairs_q, cnt_pairs_d;
    logic [CNT_W-1:0] cnt_singles_q, cnt_singles_d;
    logic [CNT_W-1:0] cnt_stalls_q, cnt_stalls_d;

    always_comb begin
        cnt_pairs_d   = cnt_pairs_q + CNT_W'(bus.issue1_valid && bus.issue2_valid);
        cnt_singles_d = cnt_singles_q + CNT_W'(bus.issue1_valid ^ bus.issue2_valid);
        cnt_stalls_d  = cnt_stalls_q + CNT_W'(stalled);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_pairs_q   <= '0;
            cnt_singles_q <= '0;
            cnt_stalls_q  <= '0;
        end else begin
            cnt_pairs_q   <= cnt_pairs_d;
            cnt_singles_q <= cnt_singles_d;
            cnt_stalls_q  <= cnt_stalls_d;
        end
    end

    assign cnt_pairs   = cnt_pairs_q;
    assign cnt_singles = cnt_singles_q;
    assign cnt_stalls  = cnt_stalls_q;
`endif
endmodule
